// File: rtl/decode_inst_queue_pkg.sv
// Shared definitions for the pre-decoding instruction queue: instruction
// classes, MIPS-I opcode/function constants and the stored predecode record.
package decode_inst_queue_pkg;

  typedef enum logic [2:0] {
    CLS_ALU    = 3'd0,
    CLS_LOAD   = 3'd1,
    CLS_STORE  = 3'd2,
    CLS_BRANCH = 3'd3,
    CLS_JUMP   = 3'd4,
    CLS_MULDIV = 3'd5,
    CLS_PRIV   = 3'd6,
    CLS_RSVD   = 3'd7
  } cls_e;

  localparam logic [4:0] REG_RA = 5'd31;

  // primary opcodes
  localparam logic [5:0] OP_SPECIAL = 6'h00;
  localparam logic [5:0] OP_REGIMM  = 6'h01;
  localparam logic [5:0] OP_J       = 6'h02;
  localparam logic [5:0] OP_JAL     = 6'h03;
  localparam logic [5:0] OP_BEQ     = 6'h04;
  localparam logic [5:0] OP_BNE     = 6'h05;
  localparam logic [5:0] OP_BLEZ    = 6'h06;
  localparam logic [5:0] OP_BGTZ    = 6'h07;
  localparam logic [5:0] OP_ADDI    = 6'h08;
  localparam logic [5:0] OP_ADDIU   = 6'h09;
  localparam logic [5:0] OP_SLTI    = 6'h0A;
  localparam logic [5:0] OP_SLTIU   = 6'h0B;
  localparam logic [5:0] OP_ANDI    = 6'h0C;
  localparam logic [5:0] OP_ORI     = 6'h0D;
  localparam logic [5:0] OP_XORI    = 6'h0E;
  localparam logic [5:0] OP_LUI     = 6'h0F;
  localparam logic [5:0] OP_COP0    = 6'h10;
  localparam logic [5:0] OP_LB      = 6'h20;
  localparam logic [5:0] OP_LH      = 6'h21;
  localparam logic [5:0] OP_LWL     = 6'h22;
  localparam logic [5:0] OP_LW      = 6'h23;
  localparam logic [5:0] OP_LBU     = 6'h24;
  localparam logic [5:0] OP_LHU     = 6'h25;
  localparam logic [5:0] OP_LWR     = 6'h26;
  localparam logic [5:0] OP_SB      = 6'h28;
  localparam logic [5:0] OP_SH      = 6'h29;
  localparam logic [5:0] OP_SWL     = 6'h2A;
  localparam logic [5:0] OP_SW      = 6'h2B;
  localparam logic [5:0] OP_SWR     = 6'h2E;

  // SPECIAL function codes
  localparam logic [5:0] FN_SLL     = 6'h00;
  localparam logic [5:0] FN_SRL     = 6'h02;
  localparam logic [5:0] FN_SRA     = 6'h03;
  localparam logic [5:0] FN_SLLV    = 6'h04;
  localparam logic [5:0] FN_SRLV    = 6'h06;
  localparam logic [5:0] FN_SRAV    = 6'h07;
  localparam logic [5:0] FN_JR      = 6'h08;
  localparam logic [5:0] FN_JALR    = 6'h09;
  localparam logic [5:0] FN_SYSCALL = 6'h0C;
  localparam logic [5:0] FN_BREAK   = 6'h0D;
  localparam logic [5:0] FN_MFHI    = 6'h10;
  localparam logic [5:0] FN_MTHI    = 6'h11;
  localparam logic [5:0] FN_MFLO    = 6'h12;
  localparam logic [5:0] FN_MTLO    = 6'h13;
  localparam logic [5:0] FN_MULT    = 6'h18;
  localparam logic [5:0] FN_MULTU   = 6'h19;
  localparam logic [5:0] FN_DIV     = 6'h1A;
  localparam logic [5:0] FN_DIVU    = 6'h1B;
  localparam logic [5:0] FN_ADD     = 6'h20;
  localparam logic [5:0] FN_ADDU    = 6'h21;
  localparam logic [5:0] FN_SUB     = 6'h22;
  localparam logic [5:0] FN_SUBU    = 6'h23;
  localparam logic [5:0] FN_AND     = 6'h24;
  localparam logic [5:0] FN_OR      = 6'h25;
  localparam logic [5:0] FN_XOR     = 6'h26;
  localparam logic [5:0] FN_NOR     = 6'h27;
  localparam logic [5:0] FN_SLT     = 6'h2A;
  localparam logic [5:0] FN_SLTU    = 6'h2B;

  // REGIMM rt selectors and COP0 rs selectors
  localparam logic [4:0] RT_BLTZ    = 5'h00;
  localparam logic [4:0] RT_BGEZ    = 5'h01;
  localparam logic [4:0] RT_BLTZAL  = 5'h10;
  localparam logic [4:0] RT_BGEZAL  = 5'h11;
  localparam logic [4:0] RS_MF      = 5'h00;
  localparam logic [4:0] RS_MT      = 5'h04;

  localparam logic [31:0] INST_ERET = 32'h4200_0018;

  typedef struct packed {
    logic [2:0] cls;
    logic [4:0] dest;
    logic       dest_we;
    logic       ri_exc;
  } pd_t;

endpackage

// File: rtl/decode_inst_queue_predecode.sv
// Purely combinational predecoder: classifies one MIPS-I word and picks the
// GPR it writes, so decode never has to re-derive these from the raw bits.
module inst_predecode
  import decode_inst_queue_pkg::*;
(
  input  logic [31:0] inst_i,
  output cls_e        cls_o,
  output logic [4:0]  dest_o,
  output logic        dest_we_o,
  output logic        ri_exc_o
);

  logic [5:0] opcode;
  logic [5:0] func;
  logic [4:0] rs;
  logic [4:0] rt;
  logic [4:0] rd;

  assign opcode = inst_i[31:26];
  assign rs     = inst_i[25:21];
  assign rt     = inst_i[20:16];
  assign rd     = inst_i[15:11];
  assign func   = inst_i[5:0];

  always_comb begin
    cls_o  = CLS_RSVD;
    dest_o = 5'd0;
    case (opcode)
      OP_SPECIAL: begin
        case (func)
          FN_SLL, FN_SRL, FN_SRA, FN_SLLV, FN_SRLV, FN_SRAV,
          FN_ADD, FN_ADDU, FN_SUB, FN_SUBU, FN_AND, FN_OR,
          FN_XOR, FN_NOR, FN_SLT, FN_SLTU, FN_MFHI, FN_MFLO: begin
            cls_o  = CLS_ALU;
            dest_o = rd;
          end
          FN_JR:   cls_o = CLS_JUMP;
          FN_JALR: begin
            cls_o  = CLS_JUMP;
            dest_o = rd;
          end
          FN_SYSCALL, FN_BREAK: cls_o = CLS_PRIV;
          FN_MTHI, FN_MTLO, FN_MULT, FN_MULTU, FN_DIV, FN_DIVU:
            cls_o = CLS_MULDIV;
          default: cls_o = CLS_RSVD;
        endcase
      end
      OP_REGIMM: begin
        case (rt)
          RT_BLTZ, RT_BGEZ: cls_o = CLS_BRANCH;
          RT_BLTZAL, RT_BGEZAL: begin
            cls_o  = CLS_BRANCH;
            dest_o = REG_RA;
          end
          default: cls_o = CLS_RSVD;
        endcase
      end
      OP_J:   cls_o = CLS_JUMP;
      OP_JAL: begin
        cls_o  = CLS_JUMP;
        dest_o = REG_RA;
      end
      OP_BEQ, OP_BNE, OP_BLEZ, OP_BGTZ: cls_o = CLS_BRANCH;
      OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU,
      OP_ANDI, OP_ORI, OP_XORI, OP_LUI: begin
        cls_o  = CLS_ALU;
        dest_o = rt;
      end
      // eret is matched on the whole word; other COP0 forms go by rs
      OP_COP0: begin
        if (inst_i == INST_ERET) begin
          cls_o = CLS_PRIV;
        end else if (rs == RS_MF) begin
          cls_o  = CLS_PRIV;
          dest_o = rt;
        end else if (rs == RS_MT) begin
          cls_o = CLS_PRIV;
        end
      end
      OP_LB, OP_LH, OP_LWL, OP_LW, OP_LBU, OP_LHU, OP_LWR: begin
        cls_o  = CLS_LOAD;
        dest_o = rt;
      end
      OP_SB, OP_SH, OP_SWL, OP_SW, OP_SWR: cls_o = CLS_STORE;
      default: cls_o = CLS_RSVD;
    endcase
  end

  assign dest_we_o = (dest_o != 5'd0);
  assign ri_exc_o  = (cls_o == CLS_RSVD);

endmodule

// File: rtl/decode_inst_queue.sv
// Pre-decoding circular instruction queue between fetch and decode, with
// delay-slot tagging at enqueue and a synchronous flush for redirects.
module decode_inst_queue
  import decode_inst_queue_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int PTR_W = $clog2(DEPTH),
  parameter int PC_W  = 32
) (
  input  logic            clk,
  input  logic            resetn,
  input  logic            flush,
  input  logic            fs_valid,
  input  logic [PC_W-1:0] fs_pc,
  input  logic [31:0]     fs_inst,
  output logic            fs_ready,
  output logic            ds_valid,
  input  logic            ds_ready,
  output logic [PC_W-1:0] ds_pc,
  output logic [31:0]     ds_inst,
  output logic [2:0]      ds_cls,
  output logic [4:0]      ds_dest,
  output logic            ds_dest_we,
  output logic            ds_bd,
  output logic            ds_ri_exc,
  output logic [PTR_W:0]  count
);

  localparam int CNT_W = PTR_W + 1;

  logic [PTR_W-1:0] head_q, head_d;
  logic [PTR_W-1:0] tail_q, tail_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             last_br_q, last_br_d;

  logic [PC_W-1:0]  pc_q   [DEPTH];
  logic [31:0]      inst_q [DEPTH];
  pd_t              pd_q   [DEPTH];
  logic             bd_q   [DEPTH];

  cls_e       pd_cls;
  logic [4:0] pd_dest;
  logic       pd_dest_we;
  logic       pd_ri_exc;
  logic       enq;
  logic       deq;

  inst_predecode u_predecode (
    .inst_i    (fs_inst),
    .cls_o     (pd_cls),
    .dest_o    (pd_dest),
    .dest_we_o (pd_dest_we),
    .ri_exc_o  (pd_ri_exc)
  );

  // Both handshakes depend only on registered occupancy.
  assign fs_ready = (count_q != CNT_W'(DEPTH));
  assign ds_valid = (count_q != '0);
  assign enq      = fs_valid && fs_ready && !flush;
  assign deq      = ds_valid && ds_ready && !flush;

  always_comb begin
    head_d    = head_q;
    tail_d    = tail_q;
    count_d   = count_q;
    last_br_d = last_br_q;
    if (flush) begin
      head_d    = '0;
      tail_d    = '0;
      count_d   = '0;
      last_br_d = 1'b0;
    end else begin
      if (enq) begin
        tail_d    = tail_q + PTR_W'(1);
        last_br_d = (pd_cls == CLS_BRANCH) || (pd_cls == CLS_JUMP);
      end
      if (deq) begin
        head_d = head_q + PTR_W'(1);
      end
      case ({enq, deq})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      head_q    <= '0;
      tail_q    <= '0;
      count_q   <= '0;
      last_br_q <= 1'b0;
    end else begin
      head_q    <= head_d;
      tail_q    <= tail_d;
      count_q   <= count_d;
      last_br_q <= last_br_d;
    end
  end

  // Entry payload needs no reset: it is only observed while count_q covers it.
  always_ff @(posedge clk) begin
    if (enq) begin
      pc_q[tail_q]   <= fs_pc;
      inst_q[tail_q] <= fs_inst;
      pd_q[tail_q]   <= '{cls: pd_cls, dest: pd_dest,
                          dest_we: pd_dest_we, ri_exc: pd_ri_exc};
      bd_q[tail_q]   <= last_br_q;
    end
  end

  pd_t head_pd;
  assign head_pd = pd_q[head_q];

  assign ds_pc      = ds_valid ? pc_q[head_q]   : '0;
  assign ds_inst    = ds_valid ? inst_q[head_q] : '0;
  assign ds_cls     = ds_valid ? head_pd.cls     : 3'd0;
  assign ds_dest    = ds_valid ? head_pd.dest    : 5'd0;
  assign ds_dest_we = ds_valid && head_pd.dest_we;
  assign ds_ri_exc  = ds_valid && head_pd.ri_exc;
  assign ds_bd      = ds_valid && bd_q[head_q];
  assign count      = count_q;

endmodule

// File: doc/decode_inst_queue.md
Name: decode_inst_queue

Overview:
- Parametrised pre-decoding instruction queue between fetch and decode.
- Accepts fetched {pc, inst} through a valid/ready handshake and predecodes each word at enqueue time.
- Stores the word with its predecoded fields in a circular buffer of DEPTH entries.
- Tracks branch delay slots across enqueues and presents the head entry to decode through a second valid/ready handshake, with a synchronous flush for exceptions/eret.

Parameters:
- DEPTH, 4: number of queue entries; power of two, 2..16.
- PTR_W, $clog2(DEPTH): pointer width (derived, not overridden).
- PC_W, 32: program-counter width.

Ports:
- clk  in  1  clock.
- resetn  in  1  asynchronous active-low reset.
- flush  in  1  synchronous queue clear (exception/eret redirect).
- fs_valid  in  1  fetch offers an instruction.
- fs_pc  in  PC_W  PC of offered instruction.
- fs_inst  in  32  offered instruction word.
- fs_ready  out  1  queue can accept this cycle.
- ds_valid  out  1  head entry valid.
- ds_ready  in  1  decode consumes head this cycle.
- ds_pc  out  PC_W  head PC.
- ds_inst  out  32  head instruction word.
- ds_cls  out  3  head instruction class.
- ds_dest  out  5  head destination register (0 if none).
- ds_dest_we  out  1  head writes a GPR.
- ds_bd  out  1  head sits in a branch delay slot.
- ds_ri_exc  out  1  head is a reserved instruction.
- count  out  PTR_W+1  current occupancy.

Behaviour:
- Reset (async, resetn=0): head=tail=0, count=0, last_br=0, ds_valid=0, fs_ready=1.
  - All ds_* data outputs read 0 while empty (masked by ds_valid).
- Enqueue:
  - Fires when fs_valid && fs_ready && !flush; writes entry[tail], tail+1 modulo DEPTH.
  - fs_ready = (count != DEPTH). It depends only on registered state; there is no combinational path from ds_ready.
- Dequeue:
  - Fires when ds_valid && ds_ready && !flush; head+1 modulo DEPTH.
  - ds_valid = (count != 0). Head outputs come directly from entry[head], with zero-cycle latency from storage.
- Simultaneous enqueue and dequeue: count unchanged, both pointers advance. This is legal at full (fs_ready=0 blocks enqueue, so no overflow) and at empty (ds_valid=0 blocks dequeue).
- Latency: a word enqueued in cycle N is visible at ds_* in cycle N+1. There is no bypass.
- Flush has priority over everything:
  - Next cycle: head=tail=0, count=0, last_br=0.
  - Any enqueue or dequeue in the flush cycle is discarded.
- Predecode at enqueue (combinational on fs_inst, result stored):
  - cls encoding: 0=ALU, 1=LOAD, 2=STORE, 3=BRANCH (beq/bne/bgez/bgtz/blez/bltz/bltzal/bgezal), 4=JUMP (j/jal/jr/jalr), 5=MULDIV (mult/multu/div/divu/mthi/mtlo), 6=PRIV (eret/mfc0/mtc0/syscall/break), 7=RSVD.
  - Instruction coverage is the full MIPS-I integer subset of the existing decoder, including lb/lbu/lh/lhu/lwl/lwr/sb/sh/swl/swr.
  - ri_exc=1 iff cls=RSVD.
  - dest selection:
    - rt for I-type ALU, loads, and mfc0.
    - 31 for jal/bltzal/bgezal.
    - rd for R-type writers, jalr, and mfhi/mflo.
    - Otherwise 0.
  - dest_we=1 iff dest!=0.
- Delay-slot tracking:
  - last_br is set on enqueue of a BRANCH or JUMP word and cleared on enqueue of any other word.
  - The stored bd equals last_br before the update.
  - last_br persists across empty cycles; it is cleared only by flush or reset.
- Reset mid-operation: the queue is emptied immediately; no partial entry survives.

Decomposition:
- defines.h gains: CLS_ALU..CLS_RSVD (3-bit) and the opcode/func constants used by predecode.
- Sub-module inst_predecode (pure combinational: inst -> cls, dest, dest_we, ri_exc) is instantiated once at the enqueue port.
- Storage: flat registers indexed by pointer, not a RAM macro.

Test Plan:
- Reset, then push addiu $2,$0,5 (0x24020005) at pc 0xBFC00000 -> next cycle ds_valid=1, cls=0, dest=2, dest_we=1, bd=0, count=1.
- Push DEPTH=4 words with ds_ready=0 -> fs_ready=0 after the 4th, count=4; a 5th fs_valid is held, not lost. Assert ds_ready for one cycle -> count=3, fs_ready=1.
- Push beq (0x10220003), then addu (0x00221821) -> second entry ds_bd=1, dest=3; a third word pushed after it -> bd=0.
- Push 0xFC000000 -> ds_ri_exc=1, cls=7, dest_we=0.
- Fill to 3 entries, assert flush together with fs_valid and ds_ready -> next cycle count=0, ds_valid=0, last_br=0; the flushed-cycle word is absent.
- Continuous push/pop at full rate for 2*DEPTH+3 words -> pointer wrap exercised, output order and PCs match input exactly, count constant at 1.
